// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared widths, reset level and FIFO entry type for the fetch stage.
package pc_fetch_pkg;
    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS = 32;
    localparam logic [INST_BUS-1:0] ZERO_WORD = '0;
    localparam logic RST_ENABLE = 1'b0;
    typedef struct packed {
        logic [INST_ADDR_BUS-1:0] pc;
        logic [INST_BUS-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory handshake plus decode-side delivery signals.
interface pc_fetch_if;
    import pc_fetch_pkg::*;
    logic imem_req_o;
    logic [INST_ADDR_BUS-1:0] imem_addr_o;
    logic imem_gnt_i;
    logic imem_rvalid_i;
    logic [INST_BUS-1:0] imem_rdata_i;
    logic branch_flag_i;
    logic [INST_ADDR_BUS-1:0] branch_target_i;
    logic stall_i;
    logic valid_o;
    logic [INST_ADDR_BUS-1:0] pc_o;
    logic [INST_BUS-1:0] inst_o;
    modport master(
        output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
        input imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_flag_i, branch_target_i, stall_i
    );
    modport slave(
        input imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_flag_i, branch_target_i, stall_i
    );
endinterface

// File: rtl/pc_fetch_fifo.sv
// pc_fetch_fifo: {pc, inst} buffer with wrap-bit pointers; clear wins over push/pop.
module pc_fetch_fifo
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);
    fetch_entry_t r_mem [DEPTH];
    logic [CW-1:0] r_wp, r_rp;
    assign o_count = r_wp - r_rp;
    assign o_empty = o_count == '0;
    assign o_full = o_count == CW'(DEPTH);
    assign o_head = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (i_clear) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            r_wp <= r_wp + CW'(i_push);
            r_rp <= r_rp + CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wp[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC owner and in-order fetcher; credits bound FIFO occupancy plus in-flight requests.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    pc_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [INST_ADDR_BUS-1:0] r_fetch_pc, r_resp_pc, w_target;
    logic [CW-1:0] r_outstanding, r_discard, w_count;
    logic w_req, w_gnt, w_push, w_pop, w_full, w_empty;
    fetch_entry_t w_head;
    assign w_target = bus.branch_target_i & 32'hFFFF_FFFC;
    assign w_req = (rst != RST_ENABLE) && !bus.branch_flag_i &&
                   ({1'b0, w_count} + {1'b0, r_outstanding} < (CW+1)'(DEPTH));
    assign w_gnt = w_req && bus.imem_gnt_i;
    assign w_push = bus.imem_rvalid_i && !bus.branch_flag_i && r_discard == '0;
    assign w_pop = !w_empty && !bus.stall_i && !bus.branch_flag_i;
    assign bus.imem_req_o = w_req;
    assign bus.imem_addr_o = r_fetch_pc;
    assign bus.valid_o = !w_empty;
    assign bus.pc_o = w_head.pc;
    assign bus.inst_o = w_head.inst;
    pc_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.branch_flag_i),
        .i_data  ('{pc: r_resp_pc, inst: bus.imem_rdata_i}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );
    // On redirect every request still unanswered after this cycle becomes stale.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_outstanding <= '0;
            r_discard <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(bus.imem_rvalid_i);
            if (bus.branch_flag_i) begin
                r_fetch_pc <= w_target;
                r_resp_pc <= w_target;
                r_discard <= r_outstanding - CW'(bus.imem_rvalid_i);
            end else begin
                if (w_gnt) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
                if (bus.imem_rvalid_i && r_discard != '0) r_discard <= r_discard - CW'(1);
            end
        end
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
        !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed fetch scenarios against a variable-latency memory; monitor checks deliveries.
module tb_pc_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_en = 1'b0;
    int lat = 1;
    int total = 0;
    int bad = 0;
    logic [2:0] pv;
    logic [31:0] pd [3];
    logic [63:0] q [$];
    always #5 clk = ~clk;
    pc_fetch_if bus();
    pc_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.imem_gnt_i = mem_en;
    assign bus.imem_rvalid_i = pv[lat-1];
    assign bus.imem_rdata_i = pd[lat-1];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[1:0], bus.imem_req_o && mem_en};
            pd[0] <= bus.imem_addr_o ^ 32'hFFFF_FFFF;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    always @(negedge clk) begin
        if (rst && bus.valid_o && !bus.stall_i) begin
            logic [63:0] e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected delivery pc=%h inst=%h", bus.pc_o, bus.inst_o);
            end else begin
                e = q.pop_front();
                if ({bus.pc_o, bus.inst_o} !== e) begin
                    bad++;
                    $display("FAIL deliver got pc=%h inst=%h want pc=%h inst=%h",
                             bus.pc_o, bus.inst_o, e[63:32], e[31:0]);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask
    function automatic void expect_pc(input logic [31:0] pc);
        q.push_back({pc, pc ^ 32'hFFFF_FFFF});
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.stall_i = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = '0;
        step();
        step();
        chk("rst_req", 32'(bus.imem_req_o), 0);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_pc", bus.pc_o, 0);
        chk("rst_inst", bus.inst_o, 0);
        // streaming: 8 grants, one delivery per cycle from cycle 2
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        rst = 1'b1;
        mem_en = 1'b1;
        #1;
        chk("first_req", 32'(bus.imem_req_o), 1);
        chk("first_addr", bus.imem_addr_o, 32'h0);
        for (int c = 0; c < 12; c++) begin
            if (c == 8) mem_en = 1'b0;
            if (c >= 2 && c <= 9) chk("thru_valid", 32'(bus.valid_o), 1);
            if (c == 10) chk("thru_end", 32'(bus.valid_o), 0);
            step();
        end
        repeat (4) step();
        chk("drain_stream", q.size(), 0);
        // stall: credits cap at 4 grants, head held
        for (int i = 8; i < 12; i++) expect_pc(32'(i * 4));
        bus.stall_i = 1'b1;
        mem_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 2) chk("stall_pc_early", bus.pc_o, 32'd32);
            if (c == 3) chk("stall_req_last", 32'(bus.imem_req_o), 1);
            if (c == 4) chk("stall_req_drop", 32'(bus.imem_req_o), 0);
            if (c == 9) begin
                chk("stall_req_held", 32'(bus.imem_req_o), 0);
                chk("stall_pc_held", bus.pc_o, 32'd32);
                chk("stall_inst_held", bus.inst_o, 32'hFFFF_FFDF);
            end
            step();
        end
        bus.stall_i = 1'b0;
        mem_en = 1'b0;
        repeat (8) step();
        chk("drain_stall", q.size(), 0);
        // redirect with two requests in flight (3-cycle memory)
        lat = 3;
        expect_pc(32'h0000_1000);
        mem_en = 1'b1;
        step();
        step();
        mem_en = 1'b0;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h0000_1003;
        #1;
        chk("br_no_req", 32'(bus.imem_req_o), 0);
        step();
        bus.branch_flag_i = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("br_tgt_req", 32'(bus.imem_req_o), 1);
        chk("br_tgt_addr", bus.imem_addr_o, 32'h0000_1000);
        chk("br_valid_b1", 32'(bus.valid_o), 0);
        step();
        mem_en = 1'b0;
        step();
        step();
        chk("br_valid_b4", 32'(bus.valid_o), 0);
        repeat (6) step();
        chk("drain_br", q.size(), 0);
        // redirect colliding with response and grant, target near wrap
        lat = 1;
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        mem_en = 1'b1;
        step();
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'hFFFF_FFFA;
        #1;
        chk("col_no_req", 32'(bus.imem_req_o), 0);
        step();
        bus.branch_flag_i = 1'b0;
        #1;
        chk("col_tgt_addr", bus.imem_addr_o, 32'hFFFF_FFF8);
        chk("col_tgt_req", 32'(bus.imem_req_o), 1);
        step();
        step();
        step();
        mem_en = 1'b0;
        repeat (6) step();
        chk("drain_wrap", q.size(), 0);
        // asynchronous reset with three buffered entries
        bus.stall_i = 1'b1;
        mem_en = 1'b1;
        step();
        step();
        step();
        mem_en = 1'b0;
        step();
        chk("pre_rst_valid", 32'(bus.valid_o), 1);
        chk("pre_rst_pc", bus.pc_o, 32'h4);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.valid_o), 0);
        chk("arst_req", 32'(bus.imem_req_o), 0);
        chk("arst_pc", bus.pc_o, 0);
        step();
        step();
        expect_pc(32'h0);
        rst = 1'b1;
        bus.stall_i = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("rel_req", 32'(bus.imem_req_o), 1);
        chk("rel_addr", bus.imem_addr_o, 32'h0);
        step();
        mem_en = 1'b0;
        repeat (5) step();
        chk("drain_rst", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the openMIPS pipeline. Owns the program counter, issues in-order word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small FIFO. Feeds the decode stage with `pc_o`/`inst_o` under `valid_o`/`stall_i` flow control, and redirects on branches by flushing buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.
- `DEPTH`, default 4: FIFO entries, and also the limit on FIFO occupancy plus outstanding requests. Power of two, ≥2.
- `clk` in 1: the single clock. All state is updated on the rising edge.
- `rst` in 1: reset, asynchronous and active-low. The block is in reset while `rst`=0.
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out 32: fetch address, word aligned.
- `imem_gnt_i` in 1: the request is accepted in a cycle where `imem_req_o` and `imem_gnt_i` are both 1.
- `imem_rvalid_i` in 1: a response word is present this cycle. Responses return in request order, at least 1 cycle after the grant.
- `imem_rdata_i` in 32: response instruction word.
- `branch_flag_i` in 1: redirect request, 1-cycle pulse.
- `branch_target_i` in 32: redirect address. Bits [1:0] are ignored and treated as 00.
- `stall_i` in 1: decode cannot accept an instruction this cycle.
- `valid_o` out 1: `pc_o`/`inst_o` hold a valid instruction.
- `pc_o` out 32: PC of the presented instruction.
- `inst_o` out 32: presented instruction word.

## Operation
- Internal state:
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of the next response to be kept.
  - `outstanding`: requests granted but not yet answered.
  - `discard`: responses still to be dropped.
  - FIFO of {pc, inst} entries.
- Request issue:
  - `imem_req_o` = (`count` + `outstanding` < DEPTH) && !`branch_flag_i`.
  - `imem_addr_o` = `fetch_pc`.
  - There is no combinational path from `stall_i` to `imem_req_o`.
  - On grant: `fetch_pc` += 4 (wraps modulo 2^32) and `outstanding` += 1.
- Response handling:
  - On `imem_rvalid_i`, `outstanding` −= 1.
  - If `discard` > 0: drop the word and decrement `discard`.
  - Otherwise: push {`resp_pc`, `imem_rdata_i`} into the FIFO and increment `resp_pc` by 4.
  - A grant and a response in the same cycle leave `outstanding` unchanged.
- Delivery:
  - `valid_o` = FIFO not empty. `pc_o`/`inst_o` show the FIFO head.
  - The head pops when `valid_o` && !`stall_i`.
  - Push and pop may occur in the same cycle, including when the FIFO is full; credit accounting guarantees no overflow.
  - An empty FIFO is never popped.
- Redirect (`branch_flag_i`=1), which takes priority over stall, grant and response:
  - FIFO is cleared.
  - `fetch_pc` and `resp_pc` are loaded with {target[31:2], 2'b00}.
  - `discard` = requests still unanswered after this cycle's response, counting any already pending discards.
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is always dropped.
- Reset values:
  - `imem_req_o`=0 while in reset.
  - `fetch_pc`=`resp_pc`=RESET_PC.
  - `outstanding`=`discard`=0, FIFO empty, `valid_o`=0.
  - `pc_o`=0 and `inst_o`=0 when empty.
- Reset mid-operation:
  - All state clears immediately (asynchronous).
  - In-flight memory responses arriving after reset release are a system-level error. The memory is reset by the same `rst`.

## Timing
- First request appears in the first cycle after `rst` deasserts, with address RESET_PC.
- Response in cycle N gives `valid_o`=1 in cycle N+1 (registered FIFO).
- With a 1-cycle memory and `stall_i`=0, throughput is one instruction per cycle from the third cycle after reset release.
- Redirect in cycle B:
  - First request to the target is in B+1.
  - `valid_o`=0 from B+1 until the target's response is pushed.
- `stall_i` held: the FIFO fills to DEPTH−`outstanding`, then `imem_req_o` drops. `pc_o`/`inst_o` hold stable while stalled.

## Structure
- Shared `define.v` holds:
  - `INST_ADDR_BUS`, `INST_BUS`.
  - Zero word.
  - Reset-active constant, defined as 1'b0 for this block's active-low reset.
- Sub-module `fetch_fifo`:
  - Parameterised depth, 64-bit entries.
  - Ports: push, pop, clear, full, empty, count, head data.
- Counters are sized $clog2(DEPTH)+1 bits.

## Test plan
- Reset release, 1-cycle memory returning word = address ^ 32'hFFFF_FFFF, `stall_i`=0 → `pc_o` sequence 0,4,8,… with matching `inst_o`, and one instruction per cycle in steady state.
- `stall_i`=1 for 10 cycles → `imem_req_o` drops once `count`+`outstanding`=4. `pc_o` is held, no instruction is lost or duplicated, and delivery resumes in order.
- Redirect to 32'h0000_1003 with 2 requests outstanding → both responses are dropped and the next `valid_o` shows `pc_o`=32'h0000_1000.
- Redirect coinciding with a response and a grant → response dropped, no request issued that cycle, and the target is fetched in the next cycle.
- `fetch_pc` starting at 32'hFFFF_FFF8 → `pc_o` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst` asserted while the FIFO holds 3 entries → `valid_o`=0 and `imem_req_o`=0 immediately, and after release the first fetch is to RESET_PC.
